// File: rtl/vga_scene_sequencer.sv
// Per-frame sequencer: bounces the text-block origin and cycles palette scenes.
// Optional macro SEQ_FADE_EN adds FADE_OUT/FADE_IN brightness stepping between scenes.
module vga_scene_sequencer #(
  parameter int unsigned X_MIN       = 10,
  parameter int unsigned X_MAX       = 280,
  parameter int unsigned Y_MIN       = 10,
  parameter int unsigned Y_MAX       = 420,
  parameter int unsigned X_INIT      = 100,
  parameter int unsigned Y_INIT      = 100,
  parameter logic [7:0]  HOLD_FRAMES = 8'd240,
  parameter logic [3:0]  FADE_STEP   = 4'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync_n,
  input  logic [1:0]  speed_sel,
  input  logic        auto_en,
  input  logic        btn_next,
  output logic        frame_pulse,
  output logic [15:0] frame_cnt,
  output logic [8:0]  obj_x,
  output logic [8:0]  obj_y,
  output logic [1:0]  palette,
  output logic [1:0]  fade_level,
  output logic [1:0]  scene_state
);

  typedef enum logic [1:0] {
    SHOW     = 2'b00,
    FADE_OUT = 2'b01,
    SWITCH   = 2'b10,
    FADE_IN  = 2'b11
  } scene_e;

  localparam logic [9:0] XLO = 10'(X_MIN);
  localparam logic [9:0] XHI = 10'(X_MAX);
  localparam logic [9:0] YLO = 10'(Y_MIN);
  localparam logic [9:0] YHI = 10'(Y_MAX);

  if (FADE_STEP == 4'd0) begin : g_fade_step_chk
    $error("FADE_STEP must be at least 1");
  end

  logic        vs_q;
  logic        frame_pulse_q;
  logic [15:0] frame_cnt_q;
  logic [8:0]  x_q, y_q;
  logic        dir_x_q, dir_y_q;
  logic [1:0]  btn_q;
  scene_e      state_q;
  logic [1:0]  pal_q;
  logic [7:0]  hold_q;
`ifdef SEQ_FADE_EN
  logic [1:0]  fade_q;
  logic [3:0]  fade_cnt_q;
`endif

  logic        frame_w;
  logic        press_w;
  logic [1:0]  step_d;
  logic [9:0]  x_d, y_d;

  // Returns {dir_neg, pos}; the comparison is done one bit wider so pos+2 cannot wrap.
  function automatic logic [9:0] axis_step(input logic [8:0] pos, input logic dir_neg,
                                           input logic [1:0] step, input logic [9:0] lo,
                                           input logic [9:0] hi);
    logic [9:0] sum;
    logic [9:0] diff;
    sum       = {1'b0, pos} + {8'b0, step};
    diff      = {1'b0, pos} - {8'b0, step};
    axis_step = {dir_neg, pos};
    if (step != 2'd0) begin
      if (!dir_neg) begin
        if (sum >= hi) axis_step = {1'b1, hi[8:0]};
        else           axis_step = {1'b0, sum[8:0]};
      end else begin
        if ({1'b0, pos} <= lo + {8'b0, step}) axis_step = {1'b0, lo[8:0]};
        else                                  axis_step = {1'b1, diff[8:0]};
      end
    end
  endfunction

  assign frame_w = vs_q & ~vsync_n;
  assign press_w = btn_next & btn_q[0] & ~btn_q[1];

  always_comb begin
    step_d = 2'd0;
    case (speed_sel)
      2'b00:   step_d = 2'd1;
      2'b01:   step_d = 2'd2;
      2'b10:   step_d = {1'b0, frame_cnt_q[0]};
      default: step_d = 2'd0;
    endcase
  end

  always_comb begin
    x_d = axis_step(x_q, dir_x_q, step_d, XLO, XHI);
    y_d = axis_step(y_q, dir_y_q, step_d, YLO, YHI);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q          <= 1'b1;
      frame_pulse_q <= 1'b0;
      frame_cnt_q   <= '0;
      x_q           <= 9'(X_INIT);
      y_q           <= 9'(Y_INIT);
      dir_x_q       <= 1'b0;
      dir_y_q       <= 1'b0;
      btn_q         <= '0;
    end else begin
      vs_q          <= vsync_n;
      frame_pulse_q <= frame_w;
      if (frame_w) begin
        frame_cnt_q      <= frame_cnt_q + 16'd1;
        {dir_x_q, x_q}   <= x_d;
        {dir_y_q, y_q}   <= y_d;
        btn_q            <= {btn_q[0], btn_next};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SHOW;
      pal_q      <= '0;
      hold_q     <= '0;
`ifdef SEQ_FADE_EN
      fade_q     <= '1;
      fade_cnt_q <= '0;
`endif
    end else if (frame_w) begin
      case (state_q)
        SHOW: begin
          if (press_w || (auto_en && hold_q == HOLD_FRAMES - 8'd1)) begin
            hold_q  <= '0;
`ifdef SEQ_FADE_EN
            state_q <= FADE_OUT;
`else
            state_q <= SWITCH;
`endif
          end else if (hold_q != '1) begin
            hold_q <= hold_q + 8'd1;
          end
        end
        SWITCH: begin
          pal_q  <= pal_q + 2'd1;
          hold_q <= '0;
`ifdef SEQ_FADE_EN
          fade_cnt_q <= '0;
          state_q    <= FADE_IN;
`else
          state_q    <= SHOW;
`endif
        end
`ifdef SEQ_FADE_EN
        FADE_OUT: begin
          if (fade_cnt_q == FADE_STEP - 4'd1) begin
            fade_cnt_q <= '0;
            if (fade_q == 2'd0) state_q <= SWITCH;
            else                fade_q  <= fade_q - 2'd1;
          end else begin
            fade_cnt_q <= fade_cnt_q + 4'd1;
          end
        end
        FADE_IN: begin
          if (fade_cnt_q == FADE_STEP - 4'd1) begin
            fade_cnt_q <= '0;
            fade_q     <= fade_q + 2'd1;
            if (fade_q == 2'd2) begin
              state_q <= SHOW;
              hold_q  <= '0;
            end
          end else begin
            fade_cnt_q <= fade_cnt_q + 4'd1;
          end
        end
`endif
        default: state_q <= SHOW;
      endcase
    end
  end

  assign frame_pulse = frame_pulse_q;
  assign frame_cnt   = frame_cnt_q;
  assign obj_x       = x_q;
  assign obj_y       = y_q;
  assign palette     = pal_q;
  assign scene_state = state_q;
`ifdef SEQ_FADE_EN
  assign fade_level  = fade_q;
`else
  assign fade_level  = 2'd3;
`endif

endmodule

// File: tb/tb_vga_scene_sequencer.sv
// Randomised frame-level bench for vga_scene_sequencer against a behavioural scene/motion model.
module tb_vga_scene_sequencer;

  localparam int HOLD  = 4;
  localparam int FSTEP = 2;
  localparam int XLO = 10, XHI = 280, YLO = 10, YHI = 420;
`ifdef SEQ_FADE_EN
  localparam bit FADE_ON = 1'b1;
`else
  localparam bit FADE_ON = 1'b0;
`endif
  localparam int S_SHOW = 0, S_FOUT = 1, S_SWITCH = 2, S_FIN = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync_n = 1'b1;
  logic [1:0]  speed_sel = 2'b00;
  logic        auto_en = 1'b0;
  logic        btn_next = 1'b0;
  logic        frame_pulse;
  logic [15:0] frame_cnt;
  logic [8:0]  obj_x, obj_y;
  logic [1:0]  palette, fade_level, scene_state;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  int mx, my, mdx, mdy, mfc, mpal, mfade, mstate, mhold, mfcnt;
  bit bh1, bh2;

  vga_scene_sequencer #(
    .X_MIN(XLO), .X_MAX(XHI), .Y_MIN(YLO), .Y_MAX(YHI),
    .X_INIT(100), .Y_INIT(100),
    .HOLD_FRAMES(8'(HOLD)), .FADE_STEP(4'(FSTEP))
  ) dut (
    .clk(clk), .rst_n(rst_n), .vsync_n(vsync_n), .speed_sel(speed_sel),
    .auto_en(auto_en), .btn_next(btn_next), .frame_pulse(frame_pulse),
    .frame_cnt(frame_cnt), .obj_x(obj_x), .obj_y(obj_y), .palette(palette),
    .fade_level(fade_level), .scene_state(scene_state)
  );

  always #20 clk = ~clk;

  always @(negedge clk) if (frame_pulse === 1'b1) pulse_cnt++;

  task automatic model_reset();
    mx = 100; my = 100; mdx = 1; mdy = 1; mfc = 0;
    mpal = 0; mfade = 3; mstate = S_SHOW; mhold = 0; mfcnt = 0;
    bh1 = 1'b0; bh2 = 1'b0;
  endtask

  task automatic bounce(inout int p, inout int d, input int s, input int lo, input int hi);
    int t;
    t = p + d * s;
    if (t >= hi)      begin p = hi; d = -1; end
    else if (t <= lo) begin p = lo; d = 1;  end
    else              p = t;
  endtask

  task automatic model_frame(input int spd, input bit au, input bit b);
    int  step;
    bit  press;
    case (spd)
      0:       step = 1;
      1:       step = 2;
      2:       step = mfc % 2;
      default: step = 0;
    endcase
    if (step > 0) begin
      bounce(mx, mdx, step, XLO, XHI);
      bounce(my, mdy, step, YLO, YHI);
    end
    press = b && bh1 && !bh2;
    bh2 = bh1;
    bh1 = b;
    case (mstate)
      S_SHOW: begin
        if (press || (au && mhold == HOLD - 1)) begin
          mhold  = 0;
          mfcnt  = 0;
          mstate = FADE_ON ? S_FOUT : S_SWITCH;
        end else if (mhold < 255) mhold++;
      end
      S_FOUT: begin
        mfcnt++;
        if (mfcnt == FSTEP) begin
          mfcnt = 0;
          if (mfade == 0) mstate = S_SWITCH;
          else            mfade--;
        end
      end
      S_SWITCH: begin
        mpal   = (mpal + 1) % 4;
        mhold  = 0;
        mfcnt  = 0;
        mstate = FADE_ON ? S_FIN : S_SHOW;
      end
      default: begin
        mfcnt++;
        if (mfcnt == FSTEP) begin
          mfcnt = 0;
          mfade++;
          if (mfade == 3) begin mstate = S_SHOW; mhold = 0; end
        end
      end
    endcase
    mfc = (mfc + 1) % 65536;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; vsync_n = 1'b1; btn_next = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    pulse_cnt = 0;
  endtask

  task automatic do_frame(input int spd, input bit au, input bit b);
    bit got;
    @(negedge clk);
    speed_sel = 2'(spd); auto_en = au; btn_next = b; vsync_n = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (frame_pulse === 1'b1) begin got = 1'b1; break; end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL frame_timeout: no frame_pulse within 8 clks");
    end
    model_frame(spd, au, b);
    repeat (2) @(negedge clk);
    vsync_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #55;
    n_checks++;
    if (obj_x !== 9'd100 || scene_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_held: x=%0d st=%0d want 100/0", obj_x, scene_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    n_checks++; if (frame_pulse !== 1'b0)   begin n_fail++; $display("FAIL rst_pulse: got %b want 0", frame_pulse); end
    n_checks++; if (frame_cnt !== 16'd0)    begin n_fail++; $display("FAIL rst_fcnt: got %0d want 0", frame_cnt); end
    n_checks++; if (obj_x !== 9'd100)       begin n_fail++; $display("FAIL rst_x: got %0d want 100", obj_x); end
    n_checks++; if (obj_y !== 9'd100)       begin n_fail++; $display("FAIL rst_y: got %0d want 100", obj_y); end
    n_checks++; if (palette !== 2'd0)       begin n_fail++; $display("FAIL rst_pal: got %0d want 0", palette); end
    n_checks++; if (fade_level !== 2'd3)    begin n_fail++; $display("FAIL rst_fade: got %0d want 3", fade_level); end
    n_checks++; if (scene_state !== 2'd0)   begin n_fail++; $display("FAIL rst_state: got %0d want 0", scene_state); end
  endtask

  task automatic test_normal();
    do_reset();
    for (int f = 0; f < 3; f++) do_frame(0, 1'b0, 1'b0);
    n_checks++; if (pulse_cnt != 3)      begin n_fail++; $display("FAIL norm_pulses: got %0d want 3", pulse_cnt); end
    n_checks++; if (frame_cnt !== 16'd3) begin n_fail++; $display("FAIL norm_fcnt: got %0d want 3", frame_cnt); end
    n_checks++; if (obj_x !== 9'd103)    begin n_fail++; $display("FAIL norm_x: got %0d want 103", obj_x); end
    n_checks++; if (obj_y !== 9'd103)    begin n_fail++; $display("FAIL norm_y: got %0d want 103", obj_y); end
  endtask

  task automatic test_fast_bound();
    do_reset();
    for (int f = 1; f <= 91; f++) begin
      do_frame(1, 1'b0, 1'b0);
      n_checks++;
      if (obj_x > 9'd280 || obj_x !== 9'(mx)) begin
        n_fail++; $display("FAIL fast_x f%0d: got %0d want %0d", f, obj_x, mx);
      end
      if (f == 90) begin
        n_checks++; if (obj_x !== 9'd280) begin n_fail++; $display("FAIL fast_hit: got %0d want 280", obj_x); end
      end
      if (f == 91) begin
        n_checks++; if (obj_x !== 9'd278) begin n_fail++; $display("FAIL fast_back: got %0d want 278", obj_x); end
      end
    end
    n_checks++; if (obj_y !== 9'(my)) begin n_fail++; $display("FAIL fast_y: got %0d want %0d", obj_y, my); end
  endtask

  task automatic test_slow_pause();
    logic [15:0] fc0;
    do_reset();
    for (int f = 0; f < 4; f++) do_frame(2, 1'b0, 1'b0);
    n_checks++; if (obj_x !== 9'd102) begin n_fail++; $display("FAIL slow_x: got %0d want 102", obj_x); end
    fc0 = frame_cnt;
    for (int f = 0; f < 5; f++) do_frame(3, 1'b0, 1'b0);
    n_checks++; if (obj_x !== 9'd102) begin n_fail++; $display("FAIL pause_x: got %0d want 102", obj_x); end
    n_checks++; if (frame_cnt !== fc0 + 16'd5) begin n_fail++; $display("FAIL pause_fcnt: got %0d want %0d", frame_cnt, fc0 + 16'd5); end
  endtask

  task automatic test_auto_scene();
    int minf;
    minf = 3;
    do_reset();
    for (int f = 0; f < 40; f++) begin
      do_frame(0, 1'b1, 1'b0);
      n_checks++;
      if (scene_state !== 2'(mstate) || fade_level !== 2'(mfade)) begin
        n_fail++; $display("FAIL auto_seq f%0d: st=%0d fade=%0d want %0d/%0d", f, scene_state, fade_level, mstate, mfade);
      end
      if (int'(fade_level) < minf) minf = int'(fade_level);
      if (mpal == 1 && mstate == S_SHOW) break;
    end
    n_checks++; if (palette !== 2'd1)     begin n_fail++; $display("FAIL auto_pal: got %0d want 1", palette); end
    n_checks++; if (scene_state !== 2'd0) begin n_fail++; $display("FAIL auto_show: got %0d want 0", scene_state); end
    n_checks++;
    if (minf != (FADE_ON ? 0 : 3)) begin n_fail++; $display("FAIL auto_minfade: got %0d want %0d", minf, FADE_ON ? 0 : 3); end
  endtask

  task automatic test_button();
    int trans;
    logic [1:0] prev;
    trans = 0;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      prev = scene_state;
      do_frame(0, 1'b0, 1'b1);
      if (prev == 2'd0 && scene_state != 2'd0) trans++;
    end
    n_checks++; if (trans != 1) begin n_fail++; $display("FAIL btn_events: got %0d want 1", trans); end
    n_checks++; if (scene_state !== 2'(mstate)) begin n_fail++; $display("FAIL btn_state: got %0d want %0d", scene_state, mstate); end
    do_frame(0, 1'b0, 1'b0);
`ifdef SEQ_FADE_EN
    do_frame(0, 1'b0, 1'b1);
    do_frame(0, 1'b0, 1'b1);
    n_checks++; if (scene_state !== 2'd1) begin n_fail++; $display("FAIL btn_ignored: got %0d want 1", scene_state); end
`endif
    for (int f = 0; f < 40 && mstate != S_SHOW; f++) do_frame(0, 1'b0, 1'b0);
    for (int f = 0; f < 3; f++) do_frame(0, 1'b0, 1'b0);
    n_checks++; if (palette !== 2'd1)     begin n_fail++; $display("FAIL btn_pal: got %0d want 1", palette); end
    n_checks++; if (scene_state !== 2'd0) begin n_fail++; $display("FAIL btn_show: got %0d want 0", scene_state); end
  endtask

  task automatic test_random();
    int spd;
    bit au, b;
    do_reset();
    for (int f = 0; f < 150; f++) begin
      spd = $urandom_range(0, 3);
      au  = 1'($urandom_range(0, 1));
      b   = 1'($urandom_range(0, 1));
      do_frame(spd, au, b);
      n_checks++;
      if (frame_cnt !== 16'(mfc) || obj_x !== 9'(mx) || obj_y !== 9'(my) ||
          palette !== 2'(mpal) || fade_level !== 2'(mfade) || scene_state !== 2'(mstate)) begin
        n_fail++;
        $display("FAIL rand f%0d: fc=%0d x=%0d y=%0d pal=%0d fade=%0d st=%0d want %0d/%0d/%0d/%0d/%0d/%0d",
                 f, frame_cnt, obj_x, obj_y, palette, fade_level, scene_state, mfc, mx, my, mpal, mfade, mstate);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int f = 0; f < 20 && mstate == S_SHOW; f++) do_frame(0, 1'b1, 1'b0);
    do_frame(0, 1'b1, 1'b0);
    n_checks++; if (scene_state !== 2'(mstate)) begin n_fail++; $display("FAIL ar_pre: got %0d want %0d", scene_state, mstate); end
    @(negedge clk);
    #5 rst_n = 1'b0;
    #1;
    n_checks++;
    if (frame_cnt !== 16'd0 || obj_x !== 9'd100 || obj_y !== 9'd100 || palette !== 2'd0 ||
        fade_level !== 2'd3 || scene_state !== 2'd0 || frame_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: fc=%0d x=%0d y=%0d pal=%0d fade=%0d st=%0d want 0/100/100/0/3/0",
               frame_cnt, obj_x, obj_y, palette, fade_level, scene_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    do_frame(0, 1'b1, 1'b0);
    n_checks++;
    if (fade_level !== 2'd3 || scene_state !== 2'd0 || obj_x !== 9'd101) begin
      n_fail++; $display("FAIL ar_post: fade=%0d st=%0d x=%0d want 3/0/101", fade_level, scene_state, obj_x);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_fast_bound();
    test_slow_pause();
    test_auto_scene();
    test_button();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
